db15_joy_poller: RTL and testbench



---
 rtl/db15_joy_poller.sv | 150 +++++++++++++++
 tb/tb_db15_joy_poller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db15_joy_poller.sv
// Polls two DB15 joysticks through a 24-bit 74HC165 chain and publishes active-high button words.
// Build macro DB15_DEBOUNCE_EN: publish a frame only when it matches the previous frame's sample.
module db15_joy_poller #(
  parameter int CLK_DIV   = 48,
  parameter int GAP_TICKS = 16
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        enable,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_valid
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] CLK_LO = 3'd2;
  localparam logic [2:0] CLK_HI = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  logic [9:0]  presc_q, presc_d;
  logic        tick;
  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] joy1_q, joy2_q;
  logic [15:0] map1, map2;
  logic        fv_q;
  logic        jclk_q, jload_q;
  logic        done_tick;
  logic        publish;

  assign tick    = (presc_q == 10'(CLK_DIV - 1));
  assign presc_d = tick ? 10'd0 : presc_q + 10'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    done_tick = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d = LOAD;
            cnt_d   = 8'd0;
          end
        end
        LOAD: begin
          if (cnt_q == 8'd1) begin
            state_d = CLK_LO;
            bit_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        CLK_LO: begin
          shift_d[bit_q] = ~joy_data;
          state_d        = CLK_HI;
        end
        CLK_HI: begin
          bit_d   = bit_q + 5'd1;
          state_d = (bit_q == 5'd23) ? DONE : CLK_LO;
        end
        DONE: begin
          done_tick = 1'b1;
          state_d   = GAP;
          cnt_d     = 8'd0;
        end
        GAP: begin
          if (cnt_q == 8'(GAP_TICKS - 1)) begin
            state_d = enable ? LOAD : IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Serial bit i lands on joystick1[11-i] (i<12) and joystick2[23-i] (i>=12).
  always_comb begin
    map1 = 16'h0000;
    map2 = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      map1[11-i] = shift_q[i];
      map2[11-i] = shift_q[12+i];
    end
  end

`ifdef DB15_DEBOUNCE_EN
  logic [23:0] prev_q;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      prev_q <= 24'd0;
    end else if (done_tick) begin
      prev_q <= shift_q;
    end
  end

  assign publish = done_tick && (shift_q == prev_q);
`else
  assign publish = done_tick;
`endif

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      presc_q <= 10'd0;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      shift_q <= 24'd0;
      joy1_q  <= 16'h0000;
      joy2_q  <= 16'h0000;
      fv_q    <= 1'b0;
      jclk_q  <= 1'b0;
      jload_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fv_q    <= publish;
      // Pin levels follow the next state so they change with the FSM and never glitch.
      jclk_q  <= (state_d == CLK_HI);
      jload_q <= (state_d != LOAD);
      if (publish) begin
        joy1_q <= map1;
        joy2_q <= map2;
      end
    end
  end

  assign joy_clk     = jclk_q;
  assign joy_load    = jload_q;
  assign joystick1   = joy1_q;
  assign joystick2   = joy2_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_db15_joy_poller.sv
// Scoreboard bench for db15_joy_poller (CLK_DIV=4, GAP_TICKS=2) with a behavioural 165-chain model.
module tb_db15_joy_poller;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        enable = 1'b0;
  logic        joyData = 1'b1;
  logic        joyClk, joyLoad, frameValid;
  logic [15:0] joystick1, joystick2;

  int vectorsApplied = 0;
  int miscompares = 0;

  logic [23:0] nextPattern = 24'hFFFFFF;
  logic [23:0] curPattern = 24'hFFFFFF;
  logic [23:0] modelPrev = 24'd0;
  logic [31:0] sb[$];
  int chainIdx = 0;
  int loadStarts = 0;
  int fvCount = 0;
  logic prevLoad = 1'b1;
  logic prevJclk = 1'b0;
  logic prevFv = 1'b0;

  db15_joy_poller #(.CLK_DIV(4), .GAP_TICKS(2)) dut (
    .clk_49m    (clk),
    .reset      (rstN),
    .enable     (enable),
    .joy_data   (joyData),
    .joy_clk    (joyClk),
    .joy_load   (joyLoad),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_valid(frameValid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] mapJ1(input logic [23:0] s);
    logic [15:0] j = 16'h0000;
    for (int i = 0; i < 12; i++) j[11-i] = s[i];
    return j;
  endfunction

  function automatic logic [15:0] mapJ2(input logic [23:0] s);
    logic [15:0] j = 16'h0000;
    for (int i = 12; i < 24; i++) j[23-i] = s[i];
    return j;
  endfunction

  // Chain model plus scoreboard: a frame's expectation is pushed when its parallel load starts.
  always @(negedge clk) begin
    logic [23:0] s;
    logic expValid;
    logic [31:0] exp;
    if (!rstN) begin
      chainIdx = 0;
      prevLoad = 1'b1;
      prevJclk = 1'b0;
      prevFv   = 1'b0;
    end else begin
      if (!joyLoad) checkOutput("loadImpliesClkLow", {31'd0, joyClk}, 32'd0);
      if (!joyLoad && prevLoad) begin
        loadStarts++;
        curPattern = nextPattern;
        s = ~curPattern;
`ifdef DB15_DEBOUNCE_EN
        expValid = (s == modelPrev);
`else
        expValid = 1'b1;
`endif
        modelPrev = s;
        if (expValid) sb.push_back({mapJ1(s), mapJ2(s)});
      end
      if (!joyLoad) chainIdx = 0;
      else if (joyClk && !prevJclk) chainIdx++;
      joyData = (chainIdx < 24) ? curPattern[chainIdx] : 1'b1;
      if (frameValid) begin
        fvCount++;
        checkOutput("fvWidth", {31'd0, prevFv}, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("spuriousFv", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          checkOutput("joysticks", {joystick1, joystick2}, exp);
        end
      end
      prevLoad = joyLoad;
      prevJclk = joyClk;
      prevFv   = frameValid;
    end
  end

  task automatic waitCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [23:0] pattern, input int frames);
    int target;
    nextPattern = pattern;
    target = loadStarts + frames;
    for (int c = 0; c < frames * 300 && loadStarts < target; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("loadStarts", loadStarts, target);
  endtask

  task automatic waitChainIdx(input int idx);
    for (int c = 0; c < 600 && !(chainIdx == idx && joyLoad); c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("chainIdxReached", chainIdx, idx);
  endtask

  task automatic assertReset();
    @(posedge clk);
    #1;
    rstN = 1'b0;
    sb.delete();
    modelPrev = 24'd0;
    #1;
    checkOutput("rstJoy1", {16'd0, joystick1}, 32'd0);
    checkOutput("rstJoy2", {16'd0, joystick2}, 32'd0);
    checkOutput("rstPins", {30'd0, joyLoad, joyClk}, 32'd2);
    checkOutput("rstFv", {31'd0, frameValid}, 32'd0);
  endtask

  initial begin
    int loadLow, rises, firstRise, lastRise, fvCyc, loadStartCyc, fvBase, startBase, bad;
    logic [23:0] patA, patB;
    logic fvSeen;

    // Reset release with an idle (all-high) chain: check the first frame's shape.
    assertReset();
    waitCycles(3);
    enable = 1'b1;
    nextPattern = 24'hFFFFFF;
    rstN = 1'b1;
    loadLow = 0; rises = 0; firstRise = -1; lastRise = -1; fvCyc = -1; loadStartCyc = -1;
    fvSeen = 1'b0;
    prevJclk = 1'b0;
    for (int c = 1; c <= 400 && !fvSeen; c++) begin
      logic lastJclk;
      lastJclk = joyClk;
      @(posedge clk);
      #1;
      if (!joyLoad) begin
        loadLow++;
        if (loadStartCyc < 0) loadStartCyc = c;
      end
      if (joyClk && !lastJclk) begin
        rises++;
        if (firstRise < 0) firstRise = c;
        lastRise = c;
      end
      if (frameValid) begin
        fvSeen = 1'b1;
        fvCyc = c;
      end
    end
    checkOutput("firstFvSeen", {31'd0, fvSeen}, 32'd1);
    checkOutput("loadLowCycles", loadLow, 8);
    checkOutput("clkPulses", rises, 24);
    checkOutput("clkSpan", lastRise - firstRise, 23 * 8);
    checkOutput("fvLatency", fvCyc - loadStartCyc, 204);
    checkOutput("firstLoadCycle", loadStartCyc, 4);

    // P1 first bit and P2 last bit pressed.
    applyStimulus(24'h7FFFFE, 2);
    waitCycles(210);
    checkOutput("edgeJoy1", {16'd0, joystick1}, 32'h0800);
    checkOutput("edgeJoy2", {16'd0, joystick2}, 32'h0001);

    // Drop enable mid-frame: the frame still finishes, then the poller idles.
    waitChainIdx(10);
    fvBase = fvCount;
    enable = 1'b0;
    waitCycles(300);
    checkOutput("dropEnableFv", fvCount - fvBase, 1);
    startBase = loadStarts;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (joyClk !== 1'b0 || joyLoad !== 1'b1) bad++;
    end
    checkOutput("idleQuiet", bad, 0);
    checkOutput("noRestart", loadStarts, startBase);
    checkOutput("holdJoy1", {16'd0, joystick1}, 32'h0800);

    // Reset in the middle of a frame, then a fresh full frame.
    enable = 1'b1;
    waitChainIdx(15);
    nextPattern = 24'hFFFFFF;
    assertReset();
    waitCycles(2);
    rstN = 1'b1;
    fvCyc = -1;
    for (int c = 1; c <= 400 && fvCyc < 0; c++) begin
      @(posedge clk);
      #1;
      if (frameValid) fvCyc = c;
    end
    checkOutput("freshFrameFv", fvCyc, 208);

    // Pattern A, then B twice.
    assertReset();
    waitCycles(2);
    patA = 24'h5A5A5A;
    patB = 24'hF0F00F;
    nextPattern = patA;
    fvBase = fvCount;
    rstN = 1'b1;
    applyStimulus(patA, 1);
    applyStimulus(patB, 1);
    applyStimulus(patB, 1);
    enable = 1'b0;
    waitCycles(300);
`ifdef DB15_DEBOUNCE_EN
    checkOutput("abbFvCount", fvCount - fvBase, 1);
`else
    checkOutput("abbFvCount", fvCount - fvBase, 3);
`endif
    checkOutput("abbJoy1", {16'd0, joystick1}, {16'd0, mapJ1(~patB)});
    checkOutput("abbJoy2", {16'd0, joystick2}, {16'd0, mapJ2(~patB)});
    checkOutput("sbDrained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
